// File: rtl/gravite_colonnes_if.sv
// Play-field bus for the gravity engine: game-tick/column inputs, VGA
// counters in, stack status and pixel colour out.
// master: driven by the input logic / VGA timing side.
// slave : the gravity engine itself.
interface gravite_colonnes_if #(
   parameter int NB_COL = 3,
   parameter int HB     = 3
);
   localparam int CW = $clog2(NB_COL);

   logic                   pulse;
   logic [CW-1:0]          col;
   logic [10:0]            hpos;
   logic [10:0]            vpos;
   logic [NB_COL-1:0]      Plus;
   logic                   Aligne;
   logic                   Perdu;
   logic [HB-1:0]          Row;
   logic [NB_COL*HB-1:0]   Hauteurs;
   logic [15:0]            Score;
   logic [4:0]             Couleur;

   modport master (
      output pulse, col, hpos, vpos,
      input  Plus, Aligne, Perdu, Row, Hauteurs, Score, Couleur
   );

   modport slave (
      input  pulse, col, hpos, vpos,
      output Plus, Aligne, Perdu, Row, Hauteurs, Score, Couleur
   );
endinterface

// File: rtl/gravite_colonnes.sv
// Gravity / stacking engine for the falling-brick game.
// Keeps per-column stack heights, drops one brick per game tick, detects
// full bottom rows and game over, and paints the play field one pixel
// per cycle (registered colour, one cycle of latency).
// Optional feature macro: GRAVITE_EFFACE_EN -- when defined, a full
// bottom row is cleared (all heights drop by one) and Score counts it.
//
// state | meaning
// ------+------------------------------------------------------------
// SPAWN | waiting for a tick with a valid column to start a brick
// FALL  | brick falling in column c, one row per tick
// CHECK | one cycle after landing: game-over / full-row evaluation
// LOST  | stack reached the top; frozen until reset
module gravite_colonnes #(
   parameter int NB_COL         = 3,
   parameter int HB             = 3,
   parameter int LARGEUR_BRIQUE = 210,
   parameter int HAUTEUR_BRIQUE = 60
) (
   input logic               clk,
   input logic               reset,
   gravite_colonnes_if.slave bus
);
   localparam int            CW      = $clog2(NB_COL);
   localparam logic [HB-1:0] ROW_TOP = '1;
   localparam int            H0      = 112;
   localparam int            VB      = 492;

   typedef enum logic [1:0] {SPAWN, FALL, CHECK, LOST} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     c_q, c_d;
   logic [HB-1:0]     row_q, row_d;
   logic [HB-1:0]     h_q [NB_COL];
   logic [HB-1:0]     h_d [NB_COL];
   logic [NB_COL-1:0] plus_q, plus_d;
   logic              aligne_q, aligne_d;
   logic [15:0]       score_q, score_d;
   logic [4:0]        couleur_q, couleur_d;

   logic [HB-1:0]     h_c;
   logic              any_top;
   logic              all_set;

   // Height of the active column and the row-status summaries used by CHECK.
   always_comb begin
      h_c     = '0;
      any_top = 1'b0;
      all_set = 1'b1;
      for (int i = 0; i < NB_COL; i++) begin
         if (c_q == CW'(i)) h_c = h_q[i];
         if (h_q[i] == ROW_TOP) any_top = 1'b1;
         if (h_q[i] == '0) all_set = 1'b0;
      end
   end

   // Next-state and datapath updates; every register holds unless named.
   always_comb begin
      state_d  = state_q;
      c_d      = c_q;
      row_d    = row_q;
      h_d      = h_q;
      plus_d   = '0;
      aligne_d = 1'b0;
      score_d  = score_q;
      case (state_q)
         SPAWN: begin
            if (bus.pulse && (32'(bus.col) < NB_COL)) begin
               c_d     = bus.col;
               state_d = FALL;
            end
         end
         FALL: begin
            if (bus.pulse) begin
               // <= rather than == keeps Row from ever passing below the stack.
               if (row_q <= h_c) begin
                  for (int i = 0; i < NB_COL; i++) begin
                     if (c_q == CW'(i)) begin
                        h_d[i]    = h_q[i] + 1'b1;
                        plus_d[i] = 1'b1;
                     end
                  end
                  row_d   = ROW_TOP;
                  state_d = CHECK;
               end else begin
                  row_d = row_q - 1'b1;
               end
            end
         end
         CHECK: begin
            if (any_top) begin
               state_d = LOST;
            end else if (all_set) begin
               aligne_d = 1'b1;
`ifdef GRAVITE_EFFACE_EN
               for (int i = 0; i < NB_COL; i++) h_d[i] = h_q[i] - 1'b1;
               if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
`endif
               state_d = SPAWN;
            end else begin
               state_d = SPAWN;
            end
         end
         default: ;
      endcase
   end

   // Pixel colour for the current VGA position; falling brick over stack.
   always_comb begin
      logic [11:0] hp, vp, lo, hi, top, b_lo, b_hi;
      hp        = {1'b0, bus.hpos};
      vp        = {1'b0, bus.vpos};
      lo        = '0;
      hi        = '0;
      top       = '0;
      b_lo      = '0;
      b_hi      = '0;
      couleur_d = 5'd0;
      for (int i = 0; i < NB_COL; i++) begin
         lo  = 12'(H0 + i * LARGEUR_BRIQUE);
         hi  = 12'(H0 + (i + 1) * LARGEUR_BRIQUE);
         top = 12'(VB) - 12'(HAUTEUR_BRIQUE) * 12'(h_q[i]);
         if (hp >= lo && hp < hi && vp >= top && vp < 12'(VB)) begin
            case (i % 3)
               0:       couleur_d = 5'd9;
               1:       couleur_d = 5'd24;
               default: couleur_d = 5'd3;
            endcase
         end
         b_lo = 12'(VB) - 12'(HAUTEUR_BRIQUE) * (12'(row_q) + 12'd1);
         b_hi = 12'(VB) - 12'(HAUTEUR_BRIQUE) * 12'(row_q);
         if (state_q == FALL && c_q == CW'(i) && hp >= lo && hp < hi &&
             vp >= b_lo && vp < b_hi) begin
            couleur_d = 5'd18;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SPAWN;
         c_q       <= '0;
         row_q     <= ROW_TOP;
         for (int i = 0; i < NB_COL; i++) h_q[i] <= '0;
         plus_q    <= '0;
         aligne_q  <= 1'b0;
         score_q   <= '0;
         couleur_q <= '0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         row_q     <= row_d;
         h_q       <= h_d;
         plus_q    <= plus_d;
         aligne_q  <= aligne_d;
         score_q   <= score_d;
         couleur_q <= couleur_d;
      end
   end

   // Output mapping, heights packed column i at [i*HB +: HB].
   always_comb begin
      bus.Hauteurs = '0;
      for (int i = 0; i < NB_COL; i++) bus.Hauteurs[i*HB +: HB] = h_q[i];
   end

   assign bus.Plus    = plus_q;
   assign bus.Aligne  = aligne_q;
   assign bus.Perdu   = (state_q == LOST);
   assign bus.Row     = row_q;
   assign bus.Score   = score_q;
   assign bus.Couleur = couleur_q;
endmodule
